// File: rtl/rtc_i2c_reader.sv
// rtc_i2c_reader: byte-bus sequencer that snapshots a 7-byte RTC time block.
// Optional busy-poll timeout: `define RTC_I2C_READER_TIMEOUT_EN.
module rtc_i2c_reader #(
  parameter int         c_clk_mhz    = 50,
  parameter int         c_poll_ms    = 100,
  parameter logic [6:0] c_slave_addr = 7'h6F,
  parameter int         c_settle     = 4,
  parameter int         c_timeout    = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       trigger,
  output logic [1:0] i2c_addr,
  output logic [7:0] i2c_di,
  input  logic [7:0] i2c_do,
  output logic       i2c_csn,
  output logic       i2c_wrn,
  output logic       i2c_rdn,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] wday,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       valid,
  output logic       busy,
  output logic       error
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR3, S_WR2, S_WR1, S_WR0, S_SETTLE,
    S_POLL_RD, S_POLL_CHK, S_DATA_RD, S_DATA_CHK,
    S_DONE, S_ABORT
  } state_t;

  localparam int unsigned PER =
    unsigned'(c_clk_mhz * 1000 * c_poll_ms);
  localparam int TW = (PER > 2) ? $clog2(PER) : 1;

  state_t          state_q, state_d;
  logic [2:0]      n_q, n_d;
  logic [7:0]      set_q, set_d;
  logic [6:0][7:0] shadow_q;
  logic [6:0][7:0] time_q;
  logic            valid_q, busy_q, error_q;
  logic            auto_go;

  generate
    if (c_poll_ms != 0) begin : g_poll
      logic [TW-1:0] tmr_q;
      assign auto_go = (tmr_q == TW'(PER - 1));
      // free-running: keeps counting through snapshots
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) tmr_q <= '0;
        else         tmr_q <= auto_go ? '0 : tmr_q + TW'(1);
      end
    end else begin : g_nopoll
      assign auto_go = 1'b0;
    end
  endgenerate

`ifdef RTC_I2C_READER_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  logic        waiting;
  assign waiting = (state_q == S_SETTLE) ||
                   (state_q == S_POLL_RD) ||
                   (state_q == S_POLL_CHK);
`endif

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    set_d    = '0;
    i2c_csn  = 1'b1;
    i2c_wrn  = 1'b1;
    i2c_rdn  = 1'b1;
    i2c_addr = 2'd0;
    i2c_di   = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (trigger || auto_go) begin
          state_d = S_WR3;
          n_d     = '0;
        end
      end
      S_WR3: begin
        i2c_csn  = 1'b0;
        i2c_wrn  = 1'b0;
        i2c_addr = 2'd3;
        i2c_di   = 8'hC0;
        state_d  = S_WR2;
      end
      S_WR2: begin
        i2c_csn  = 1'b0;
        i2c_wrn  = 1'b0;
        i2c_addr = 2'd2;
        i2c_di   = {1'b0, c_slave_addr};
        state_d  = S_WR1;
      end
      S_WR1: begin
        i2c_csn  = 1'b0;
        i2c_wrn  = 1'b0;
        i2c_addr = 2'd1;
        i2c_di   = {5'd0, n_q};
        state_d  = S_WR0;
      end
      S_WR0: begin
        i2c_csn  = 1'b0;
        i2c_wrn  = 1'b0;
        state_d  = (c_settle == 0) ? S_POLL_RD : S_SETTLE;
      end
      S_SETTLE: begin
        set_d = set_q + 8'd1;
        if (set_q == 8'(c_settle - 1)) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        i2c_csn  = 1'b0;
        i2c_rdn  = 1'b0;
        i2c_addr = 2'd3;
        state_d  = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (i2c_do[7] || i2c_do[2])      state_d = S_POLL_RD;
        else if (i2c_do[6] || i2c_do[5]) state_d = S_ABORT;
        else                             state_d = S_DATA_RD;
      end
      S_DATA_RD: begin
        i2c_csn = 1'b0;
        i2c_rdn = 1'b0;
        state_d = S_DATA_CHK;
      end
      S_DATA_CHK: begin
        if (n_q == 3'd6) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + 3'd1;
          state_d = S_WR3;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef RTC_I2C_READER_TIMEOUT_EN
    to_d = to_q;
    if (state_q == S_WR0) begin
      to_d = '0;
    end else if (waiting) begin
      to_d = to_q + 32'd1;
      if (to_d >= 32'(c_timeout)) state_d = S_ABORT;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      set_q    <= '0;
      shadow_q <= '0;
      time_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      set_q   <= set_d;
      if (state_q == S_IDLE && state_d == S_WR3) busy_q <= 1'b1;
      if (state_q == S_DATA_CHK) shadow_q[n_q] <= i2c_do;
      // whole block becomes visible at once
      if (state_q == S_DONE) begin
        time_q  <= shadow_q;
        valid_q <= 1'b1;
        error_q <= 1'b0;
        busy_q  <= 1'b0;
      end
      if (state_q == S_ABORT) begin
        error_q <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

`ifdef RTC_I2C_READER_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) to_q <= '0;
    else         to_q <= to_d;
  end
`endif

  assign sec   = time_q[0];
  assign min   = time_q[1];
  assign hour  = time_q[2];
  assign wday  = time_q[3];
  assign day   = time_q[4];
  assign month = time_q[5];
  assign year  = time_q[6];
  assign valid = valid_q;
  assign busy  = busy_q;
  assign error = error_q;

endmodule

// File: tb/tb_rtc_i2c_reader.sv
// tb_rtc_i2c_reader: behavioural I2C master model plus snapshot scoreboard.
// Runs with a 1 ms / 1 MHz auto-poll so one snapshot period is 1000 cycles.
module tb_rtc_i2c_reader;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       trigger = 1'b0;
  logic [1:0] i2c_addr;
  logic [7:0] i2c_di;
  logic [7:0] i2c_do = 8'h00;
  logic       i2c_csn, i2c_wrn, i2c_rdn;
  logic [7:0] sec, min, hour, wday, day, month, year;
  logic       valid, busy, error;

  rtc_i2c_reader #(
    .c_clk_mhz   (1),
    .c_poll_ms   (1),
    .c_slave_addr(7'h6F),
    .c_settle    (4),
    .c_timeout   (50)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .trigger (trigger),
    .i2c_addr(i2c_addr),
    .i2c_di  (i2c_di),
    .i2c_do  (i2c_do),
    .i2c_csn (i2c_csn),
    .i2c_wrn (i2c_wrn),
    .i2c_rdn (i2c_rdn),
    .sec     (sec),
    .min     (min),
    .hour    (hour),
    .wday    (wday),
    .day     (day),
    .month   (month),
    .year    (year),
    .valid   (valid),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // master model state
  logic [7:0] data_m [7];
  logic [7:0] wb [4];
  int stall_cfg = 0, stall_left = 0, nack_reg = -1;
  int exp_reg = 0, cur_reg = 0;
  int nwr = 0, npoll = 0, proto_err = 0;
  bit stuck = 1'b0;
  int last_start = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) wb[i] = 8'hEE;
      i2c_do  = 8'h00;
      exp_reg = 0;
      cur_reg = 0;
    end else begin
      if (!i2c_wrn && !i2c_rdn) proto_err++;
      if (i2c_csn && (!i2c_wrn || !i2c_rdn)) proto_err++;
      if (!i2c_csn && !i2c_wrn) begin
        nwr++;
        wb[i2c_addr] = i2c_di;
        if (i2c_addr == 2'd0) begin
          if (wb[3] !== 8'hC0 || wb[2] !== 8'h6F ||
              wb[1] !== 8'(exp_reg) || i2c_di !== 8'h00)
            proto_err++;
          cur_reg    = int'(wb[1][2:0]);
          exp_reg    = exp_reg + 1;
          stall_left = stall_cfg;
          for (int i = 1; i < 4; i++) wb[i] = 8'hEE;
        end
      end
      if (!i2c_csn && !i2c_rdn) begin
        if (i2c_addr == 2'd3) begin
          npoll++;
          if (stuck || stall_left > 0) begin
            i2c_do = 8'h80;
            if (stall_left > 0) stall_left--;
          end else if (cur_reg == nack_reg) begin
            i2c_do = 8'h40;
          end else begin
            i2c_do = 8'h10;
          end
        end else if (i2c_addr == 2'd0) begin
          i2c_do = data_m[cur_reg];
        end else begin
          proto_err++;
        end
      end
    end
  end

  function automatic logic [55:0] tvec();
    return {year, month, day, wday, hour, min, sec};
  endfunction

  function automatic logic [55:0] load_data(input bit fixed);
    logic [55:0] v;
    for (int i = 0; i < 7; i++) begin
      data_m[i]    = fixed ? 8'(8'h10 + i) : 8'($urandom);
      v[8*i +: 8] = data_m[i];
    end
    return v;
  endfunction

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic run_snap(input bit trig, input bit fixed, input int stall,
                          input int nreg, input bit poke, input string tag);
    logic [55:0] prev_t, exp_t;
    logic prev_v;
    int nw0, np0, pe0, k, exp_w, exp_p;
    exp_t     = load_data(fixed);
    stall_cfg = stall;
    nack_reg  = nreg;
    exp_reg   = 0;
    nw0       = nwr;
    np0       = npoll;
    pe0       = proto_err;
    prev_t    = tvec();
    prev_v    = valid;
    if (trig) pulse_trigger();
    k = 0;
    while (!busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!busy) begin
      chk({tag, "_start"}, 64'd0, 64'd1);
      return;
    end
    last_start = cyc;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
      trigger = (poke && k == 30);
    end
    trigger = 1'b0;
    if (busy) begin
      chk({tag, "_done"}, 64'd1, 64'd0);
      return;
    end
    exp_w = (nreg < 0) ? 28 : 4 * (nreg + 1);
    exp_p = ((nreg < 0) ? 7 : nreg + 1) * (stall + 1);
    chk({tag, "_writes"}, 64'(nwr - nw0), 64'(exp_w));
    chk({tag, "_polls"}, 64'(npoll - np0), 64'(exp_p));
    chk({tag, "_proto"}, 64'(proto_err - pe0), 64'd0);
    if (nreg < 0) begin
      chk({tag, "_time"}, 64'(tvec()), 64'(exp_t));
      chk({tag, "_flags"}, {62'd0, valid, error}, 64'b10);
    end else begin
      chk({tag, "_time"}, 64'(tvec()), 64'(prev_t));
      chk({tag, "_flags"}, {62'd0, valid, error}, {62'd0, prev_v, 1'b1});
    end
  endtask

  initial begin
    int t_a, k, p0;
    logic [55:0] prev_t, exp_t;
    logic prev_v;

    repeat (3) @(negedge clk);
    chk("rst_strobes", {61'd0, i2c_csn, i2c_wrn, i2c_rdn}, 64'b111);
    chk("rst_bus", {54'd0, i2c_addr, i2c_di}, 64'd0);
    chk("rst_time", 64'(tvec()), 64'd0);
    chk("rst_flags", {61'd0, valid, busy, error}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_snap(1'b1, 1'b1, 0, -1, 1'b0, "basic");
    run_snap(1'b1, 1'b0, 20, -1, 1'b0, "stall20");
    run_snap(1'b1, 1'b0, 1, 3, 1'b0, "nack3");
    run_snap(1'b1, 1'b0, 0, -1, 1'b0, "recover");
    run_snap(1'b1, 1'b0, 2, -1, 1'b1, "trig_busy");

    for (int i = 0; i < 6; i++) begin
      int st, nr;
      st = int'($urandom_range(0, 3));
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_snap(1'($urandom_range(0, 1)), 1'b0, st, nr,
               1'($urandom_range(0, 1)), "rand");
    end

    run_snap(1'b0, 1'b0, 1, -1, 1'b0, "auto_a");
    t_a = last_start;
    run_snap(1'b0, 1'b0, 0, -1, 1'b0, "auto_b");
    chk("auto_period", 64'(last_start - t_a), 64'd1000);

    exp_t     = load_data(1'b0);
    stall_cfg = 0;
    nack_reg  = -1;
    exp_reg   = 0;
    prev_t    = tvec();
    prev_v    = valid;
    stuck     = 1'b1;
    pulse_trigger();
    k = 0;
    while (!busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("stuck_start", {63'd0, busy}, 64'd1);
    t_a = cyc;
`ifdef RTC_I2C_READER_TIMEOUT_EN
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    stuck = 1'b0;
    chk("to_len", 64'(cyc - t_a), 64'd55);
    chk("to_flags", {61'd0, valid, busy, error}, {61'd0, prev_v, 2'b01});
    chk("to_time", 64'(tvec()), 64'(prev_t));
`else
    p0 = npoll;
    repeat (10000) @(negedge clk);
    chk("stuck_busy", {62'd0, busy, error}, 64'b10);
    chk("stuck_polling", 64'(npoll - p0 > 4000), 64'd1);
    stuck = 1'b0;
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("stuck_release", {62'd0, busy, error}, 64'b00);
    chk("stuck_time", 64'(tvec()), 64'(exp_t));
`endif

    run_snap(1'b1, 1'b0, 0, -1, 1'b0, "pre_rst");
    void'(load_data(1'b0));
    stall_cfg = 1;
    nack_reg  = -1;
    exp_reg   = 0;
    pulse_trigger();
    k = 0;
    while (!(busy && cur_reg == 4) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reg4_seen", 64'(cur_reg), 64'd4);
    #2 resetn = 1'b0;
    #1;
    chk("arst_strobes", {61'd0, i2c_csn, i2c_wrn, i2c_rdn}, 64'b111);
    chk("arst_time", 64'(tvec()), 64'd0);
    chk("arst_flags", {61'd0, valid, busy, error}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_snap(1'b1, 1'b0, 0, -1, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rtc_i2c_reader.md
# rtc_i2c_reader

Autonomous sequencer that drives the 8-bit byte-bus of the I2C master to read a 7-register BCD time block from an RTC chip (default MCP7940N, slave 0x6F, subaddresses 0x00..0x06). Sits directly upstream of the I2C master, in place of the retro CPU: it issues the control-word byte writes, polls the status byte, and collects read data into an atomically updated time snapshot for the rest of the system.

## Interface
- c_clk_mhz, 50, system clock in MHz; scales the poll timer.
- c_poll_ms, 100, auto-poll period in ms; 0 disables auto-poll (trigger only).
- c_slave_addr, 7'h6F, 7-bit RTC address.
- c_settle, 4, cycles waited after the trigger write before the first status poll.
- c_timeout, 100000, busy-wait limit in cycles (used only with the timeout feature).

- clk  in  1  system clock, all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- trigger  in  1  one-cycle pulse; starts a snapshot if idle, ignored otherwise.
- i2c_addr  out  2  byte address to master.
- i2c_di  out  8  write data to master.
- i2c_do  in  8  read data from master (registered by master: valid the cycle after the read strobe).
- i2c_csn, i2c_wrn, i2c_rdn  out  1 each  active-low select/write/read strobes.
- sec, min, hour, wday, day, month, year  out  8 each  raw RTC register bytes 0x00..0x06.
- valid  out  1  at least one snapshot completed without error.
- busy  out  1  snapshot in progress.
- error  out  1  last snapshot aborted (NACK or timeout).

## Operation
- Reset values: all strobes 1, i2c_addr 0, i2c_di 0, all time bytes 0x00, valid 0, busy 0, error 0, state IDLE, reg index 0, poll timer 0.
- Start: trigger pulse, or poll timer reaching c_clk_mhz*1000*c_poll_ms-1 (timer then wraps to 0; it free-runs, including during a snapshot). Start sets busy, reg index 0.
- Per register n (0..6), states:
  - WR3: write byte 3 = 0xC0 (read, repeated start). WR2: byte 2 = {1'b0,c_slave_addr}. WR1: byte 1 = n. WR0: byte 0 = 0x00 (launches master).
  - SETTLE: c_settle cycles, strobes idle.
  - POLL_RD: read strobe, addr 3. POLL_CHK: sample i2c_do; bit7 (busy) or bit2 (init) set -> POLL_RD; bit6 or bit5 (NACK) set -> ABORT; else DATA_RD.
  - DATA_RD: read strobe, addr 0. DATA_CHK: store i2c_do to shadow[n]; n==6 -> DONE, else n+1, WR3.
- DONE: copy all 7 shadow bytes to outputs in one cycle, valid=1, error=0, busy=0 -> IDLE.
- ABORT: error=1, outputs and valid unchanged, busy=0 -> IDLE.
- Start condition arriving while busy is dropped (not queued).

## Timing
- Each bus access: exactly one cycle of csn=0 with wrn=0 or rdn=0; never both; strobes high in all other states.
- Minimum per register: 4 write + c_settle + 2 poll + 2 data = 12 cycles at c_settle=4.
- busy rises the cycle after start; outputs update and busy falls on the same edge (DONE).
- Async reset mid-snapshot: strobes deasserted immediately, no partial update of time outputs.

## Configuration
- RTC_I2C_READER_TIMEOUT_EN defined: a busy-poll counter clears on entering SETTLE and increments every cycle in SETTLE/POLL_RD/POLL_CHK; reaching c_timeout -> ABORT (error=1).
- Not defined: no counter; the sequencer waits indefinitely for the master to report not-busy.

## Test plan
- Reset then trigger, master model ACKs and returns 0x10+n for register n -> exactly 7×4 writes with bytes C0,6F,n,00; sec..year = 0x10..0x16; valid=1, error=0, busy low after last DATA_CHK.
- Master status 0x80 for 20 polls, then 0x10 -> 20 extra POLL_RD/POLL_CHK pairs, data captured correctly, no error.
- Status 0x40 (address NACK) on register 3 -> error=1, busy=0, previous time bytes and valid unchanged; next trigger with ACK clears error.
- c_poll_ms=1, c_clk_mhz=1 -> snapshots start every 1000 cycles without trigger; trigger pulse during a snapshot is ignored (write count unchanged).
- With RTC_I2C_READER_TIMEOUT_EN, c_timeout=50, status stuck 0x80 -> ABORT at 50 cycles, error=1; without the macro, still polling after 10000 cycles.
- resetn low during register 4 -> strobes high same cycle, time bytes 0x00, valid 0; new trigger completes normally.
